// File: rtl/aes_v3_pkg.sv
// rtl/aes_v3_pkg.sv - shared types and source-word selection for the AES column sequencer
package aes_v3_pkg;

  localparam int WORD_W  = 32;
  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } col_fsm_t;

  // Byte bs of output column col comes from word col+bs (ShiftRows) or col-bs (InvShiftRows).
  function automatic logic [1:0] src_word_idx(input logic [1:0] col,
                                               input logic [1:0] step,
                                               input logic       dec,
                                               input logic       shift_rows);
    if (!shift_rows)
      return col;
    else if (dec)
      return col - step;
    else
      return col + step;
  endfunction

endpackage

// File: rtl/aes_v3_col_seq.sv
// rtl/aes_v3_col_seq.sv - issues four byte operations to a shared aes_v3_2 datapath per round column
module aes_v3_col_seq
  import aes_v3_pkg::*;
#(
  parameter int SHIFT_ROWS = 1
) (
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_dec,
  input  logic               req_mix,
  input  logic [1:0]         req_col,
  input  logic [STATE_W-1:0] req_state,
  input  logic [WORD_W-1:0]  req_key,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WORD_W-1:0]  rsp_data,
  output logic               aes_valid,
  output logic               aes_dec,
  output logic               aes_mix,
  output logic [WORD_W-1:0]  aes_rs1,
  output logic [WORD_W-1:0]  aes_rs2,
  output logic [1:0]         aes_bs,
  input  logic [WORD_W-1:0]  aes_rd,
  input  logic               aes_ready
);

  col_fsm_t           r_fsm;
  logic [1:0]         r_step;
  logic               r_dec;
  logic               r_mix;
  logic [1:0]         r_col;
  logic [STATE_W-1:0] r_state;
  logic [WORD_W-1:0]  r_acc;
  logic [1:0]         w_src;

  assign w_src = src_word_idx(r_col, r_step, r_dec, SHIFT_ROWS != 0);

  // Every aes_* output is a pure function of registers, so it holds through datapath stalls.
  assign aes_valid = (r_fsm == RUN);
  assign aes_dec   = r_dec;
  assign aes_mix   = r_mix;
  assign aes_bs    = r_step;
  assign aes_rs1   = r_state[{w_src, 5'd0} +: WORD_W];
  assign aes_rs2   = r_acc;

  assign req_ready = (r_fsm == IDLE);
  assign rsp_valid = (r_fsm == DONE);
  assign rsp_data  = r_acc;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_fsm   <= IDLE;
      r_step  <= 2'd0;
      r_dec   <= 1'b0;
      r_mix   <= 1'b0;
      r_col   <= 2'd0;
      r_state <= '0;
      r_acc   <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (req_valid) begin
            r_dec   <= req_dec;
            r_mix   <= req_mix;
            r_col   <= req_col;
            r_state <= req_state;
            r_acc   <= req_key;
            r_step  <= 2'd0;
            r_fsm   <= RUN;
          end
        end
        RUN: begin
          if (aes_ready) begin
            r_acc  <= aes_rd;
            r_step <= r_step + 2'd1;
            if (r_step == 2'd3)
              r_fsm <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready)
            r_fsm <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_v3_col_seq.sv
// tb/tb_aes_v3_col_seq.sv - directed bench for aes_v3_col_seq with a small aes_v3_2 reference datapath
module tb_aes_v3_col_seq;

  logic         g_clk = 1'b0;
  logic         g_reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_dec;
  logic         req_mix;
  logic [1:0]   req_col;
  logic [127:0] req_state;
  logic [31:0]  req_key;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic         aes_valid;
  logic         aes_dec;
  logic         aes_mix;
  logic [31:0]  aes_rs1;
  logic [31:0]  aes_rs2;
  logic [1:0]   aes_bs;
  logic [31:0]  aes_rd;
  logic         aes_ready;
  logic         dp_ready;

  int errors = 0;
  int checks = 0;
  int lat;

  localparam logic [127:0] ST_ZERO = 128'h0;
  localparam logic [127:0] ST_W1   = 128'h00000000_00000000_01010101_00000000;
  localparam logic [127:0] ST_W0   = 128'h00000000_00000000_00000000_01010101;

  aes_v3_col_seq #(.SHIFT_ROWS(1)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dec   (req_dec),
    .req_mix   (req_mix),
    .req_col   (req_col),
    .req_state (req_state),
    .req_key   (req_key),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .aes_valid (aes_valid),
    .aes_dec   (aes_dec),
    .aes_mix   (aes_mix),
    .aes_rs1   (aes_rs1),
    .aes_rs2   (aes_rs2),
    .aes_bs    (aes_bs),
    .aes_rd    (aes_rd),
    .aes_ready (aes_ready)
  );

  always #5 g_clk = ~g_clk;

  // Reference datapath; S-box only covers the byte values this bench feeds in.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] b, input logic dec);
    case ({dec, b})
      9'h000:  return 8'h63;
      9'h001:  return 8'h7c;
      9'h100:  return 8'h52;
      9'h101:  return 8'h09;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0]  m_x;
  logic [31:0] m_mixed;
  logic [63:0] m_dbl;

  always_comb begin
    m_x = sb(aes_rs1[{aes_bs, 3'd0} +: 8], aes_dec);
    if (!aes_mix)
      m_mixed = {24'h0, m_x};
    else if (aes_dec)
      m_mixed = {gm(m_x, 4'hb), gm(m_x, 4'hd), gm(m_x, 4'h9), gm(m_x, 4'he)};
    else
      m_mixed = {gm(m_x, 4'h3), m_x, m_x, gm(m_x, 4'h2)};
    m_dbl  = {m_mixed, m_mixed} >> (6'd32 - {1'b0, aes_bs, 3'd0});
    aes_rd = aes_rs2 ^ m_dbl[31:0];
  end

  assign aes_ready = dp_ready;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic dec, input logic mix, input logic [1:0] col,
                        input logic [127:0] st, input logic [31:0] key);
    @(negedge g_clk);
    check("req_ready_idle", 128'(req_ready), 128'd1);
    req_valid = 1'b1;
    req_dec   = dec;
    req_mix   = mix;
    req_col   = col;
    req_state = st;
    req_key   = key;
    @(negedge g_clk);
    req_valid = 1'b0;
    req_state = ~st;
    req_key   = ~key;
    req_dec   = ~dec;
    req_mix   = ~mix;
    req_col   = ~col;
    check("issue0_valid", 128'(aes_valid), 128'd1);
    check("issue0_bs", 128'(aes_bs), 128'd0);
    check("issue0_rs2", 128'(aes_rs2), 128'(key));
    check("run_req_ready", 128'(req_ready), 128'd0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge g_clk);
      n++;
    end
  endtask

  task automatic consume();
    check("done_aes_valid", 128'(aes_valid), 128'd0);
    rsp_ready = 1'b1;
    check("done_req_ready", 128'(req_ready), 128'd0);
    @(negedge g_clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 128'(rsp_valid), 128'd0);
    check("idle_req_ready", 128'(req_ready), 128'd1);
  endtask

  task automatic run_col(input string tag, input logic dec, input logic mix, input logic [1:0] col,
                         input logic [127:0] st, input logic [31:0] key, input logic [31:0] exp);
    int n;
    do_req(dec, mix, col, st, key);
    wait_rsp(n);
    check({tag, "_lat"}, 128'(n), 128'd4);
    check({tag, "_data"}, 128'(rsp_data), 128'(exp));
    consume();
  endtask

  initial begin
    int n;
    g_reset   = 1'b1;
    req_valid = 1'b0;
    req_dec   = 1'b0;
    req_mix   = 1'b0;
    req_col   = 2'd0;
    req_state = '0;
    req_key   = '0;
    rsp_ready = 1'b0;
    dp_ready  = 1'b1;
    repeat (2) @(negedge g_clk);
    check("rst_req_ready", 128'(req_ready), 128'd1);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_data", 128'(rsp_data), 128'd0);
    check("rst_aes_valid", 128'(aes_valid), 128'd0);
    check("rst_aes_bs", 128'(aes_bs), 128'd0);
    check("rst_aes_rs1", 128'(aes_rs1), 128'd0);
    check("rst_aes_rs2", 128'(aes_rs2), 128'd0);
    check("rst_aes_dec_mix", 128'({aes_dec, aes_mix}), 128'd0);
    g_reset = 1'b0;

    run_col("enc_mix_k0",  1'b0, 1'b1, 2'd0, ST_ZERO, 32'h00000000, 32'h63636363);
    run_col("enc_mix_kff", 1'b0, 1'b1, 2'd0, ST_ZERO, 32'hffffffff, 32'h9c9c9c9c);
    run_col("dec_nomix",   1'b1, 1'b0, 2'd0, ST_ZERO, 32'h00000000, 32'h52525252);
    run_col("dec_mix",     1'b1, 1'b1, 2'd0, ST_ZERO, 32'h00000000, 32'h52525252);
    run_col("enc_shift",   1'b0, 1'b0, 2'd0, ST_W1,   32'h00000000, 32'h63637c63);
    run_col("dec_shift",   1'b1, 1'b0, 2'd0, ST_W1,   32'h00000000, 32'h09525252);
    run_col("enc_wrap",    1'b0, 1'b0, 2'd3, ST_W0,   32'h00000000, 32'h63637c63);

    // Stall issue 2 for three cycles, then hold the response for four.
    do_req(1'b0, 1'b1, 2'd0, ST_ZERO, 32'h00000000);
    repeat (2) @(negedge g_clk);
    check("stall_bs_pre", 128'(aes_bs), 128'd2);
    dp_ready = 1'b0;
    repeat (3) begin
      @(negedge g_clk);
      check("stall_valid", 128'(aes_valid), 128'd1);
      check("stall_bs", 128'(aes_bs), 128'd2);
      check("stall_rs1", 128'(aes_rs1), 128'd0);
      check("stall_rs2", 128'(aes_rs2), 128'h c600a563);
      check("stall_mix", 128'(aes_mix), 128'd1);
    end
    dp_ready = 1'b1;
    wait_rsp(n);
    check("stall_lat_tail", 128'(n), 128'd2);
    repeat (4) begin
      check("bp_rsp_valid", 128'(rsp_valid), 128'd1);
      check("bp_rsp_data", 128'(rsp_data), 128'h63636363);
      check("bp_req_ready", 128'(req_ready), 128'd0);
      @(negedge g_clk);
    end
    check("bp_rsp_data_end", 128'(rsp_data), 128'h63636363);
    consume();

    // Reset in the middle of a column.
    do_req(1'b0, 1'b1, 2'd0, ST_ZERO, 32'h00000000);
    repeat (2) @(negedge g_clk);
    check("rst_mid_bs", 128'(aes_bs), 128'd2);
    g_reset = 1'b1;
    @(negedge g_clk);
    g_reset = 1'b0;
    check("rst_mid_aes_valid", 128'(aes_valid), 128'd0);
    check("rst_mid_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_mid_req_ready", 128'(req_ready), 128'd1);
    run_col("after_rst", 1'b0, 1'b1, 2'd0, ST_ZERO, 32'h00000000, 32'h63636363);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

endmodule
